// File: rtl/t01_pkg.sv
// Shared playfield geometry, colours and controller state encoding for the line-clear block.
package t01_pkg;

    localparam int unsigned GRID_W  = 10;
    localparam int unsigned GRID_H  = 20;
    localparam int unsigned CELL_W  = 3;
    localparam int unsigned ROW_W   = GRID_W * CELL_W;
    localparam int unsigned BOARD_W = ROW_W * GRID_H;

    localparam logic [CELL_W-1:0] BLACK = 3'b000;
    localparam logic [CELL_W-1:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLASH,
        SHIFT,
        DONE
    } state_t;

    // Number of set bits in the full-row mask, saturated into the 3-bit result field.
    function automatic logic [2:0] count_lines(input logic [GRID_H-1:0] mask);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < int'(GRID_H); i++) begin
            n = n + 5'(mask[i]);
        end
        return (n > 5'd7) ? 3'd7 : n[2:0];
    endfunction

endpackage

// File: rtl/t01_row_full_detect.sv
// Flags a playfield row as full when none of its cells is BLACK.
module t01_row_full_detect
    import t01_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    output logic             full
);

    always_comb begin
        full = 1'b1;
        for (int c = 0; c < int'(GRID_W); c++) begin
            if (row[c*CELL_W +: CELL_W] == BLACK) begin
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/t01_line_clear_ctrl.sv
// Line-clear sequencer: scans for full rows, flashes them white, compacts the board
// downward and returns the result to the game FSM.
module t01_line_clear_ctrl
    import t01_pkg::*;
#(
    parameter logic [23:0] FLASH_CYCLES = 24'd10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               gameover,
    input  logic [BOARD_W-1:0] board_in,
    output logic [BOARD_W-1:0] disp_color,
    output logic [BOARD_W-1:0] board_out,
    output logic               board_we,
    output logic               busy,
    output logic               done,
    output logic [2:0]         lines_cleared
);

    state_t              state_q, state_d;
    logic [BOARD_W-1:0]  buf_q, buf_d;
    logic [GRID_H-1:0]   full_mask_q, full_mask_d;
    logic [4:0]          row_q, row_d;
    logic [23:0]         flash_cnt_q, flash_cnt_d;
    logic signed [5:0]   rd_q, rd_d;
    logic signed [5:0]   wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_q, we_d;
    logic [2:0]          lines_q, lines_d;

    logic [ROW_W-1:0]    scan_row;
    logic                scan_full;
    logic                src_ok;
    logic [4:0]          src_idx;

    assign scan_row = buf_q[int'(row_q)*ROW_W +: ROW_W];

    t01_row_full_detect u_row_full (
        .row  (scan_row),
        .full (scan_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            full_mask_q <= '0;
            row_q       <= '0;
            flash_cnt_q <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            lines_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            full_mask_q <= full_mask_d;
            row_q       <= row_d;
            flash_cnt_q <= flash_cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            we_q        <= we_d;
            lines_q     <= lines_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        full_mask_d = full_mask_q;
        row_d       = row_q;
        flash_cnt_d = flash_cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        done_d      = 1'b0;
        we_d        = 1'b0;
        lines_d     = lines_q;
        src_ok      = 1'b0;
        src_idx     = '0;

        case (state_q)
            IDLE: begin
                if (start && !gameover) begin
                    buf_d       = board_in;
                    row_d       = '0;
                    full_mask_d = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                full_mask_d[row_q] = scan_full;
                row_d              = row_q + 5'd1;
                if (row_q == 5'(GRID_H - 1)) begin
                    lines_d = count_lines(full_mask_d);
                    if (lines_d == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        flash_cnt_d = '0;
                        state_d     = FLASH;
                    end
                end
            end
            FLASH: begin
                flash_cnt_d = flash_cnt_q + 24'd1;
                if (flash_cnt_q == FLASH_CYCLES - 24'd1) begin
                    rd_d    = 6'(GRID_H - 1);
                    wr_d    = 6'(GRID_H - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Full rows at or above rd are skipped in the same cycle so every cycle fills one wr row.
                for (int i = int'(GRID_H) - 1; i >= 0; i--) begin
                    if (!src_ok && ($signed(6'(i)) <= rd_q) && !full_mask_q[i]) begin
                        src_ok  = 1'b1;
                        src_idx = 5'(i);
                    end
                end
                buf_d[int'(wr_q[4:0])*ROW_W +: ROW_W] =
                    src_ok ? buf_q[int'(src_idx)*ROW_W +: ROW_W] : '0;
                rd_d = src_ok ? ($signed({1'b0, src_idx}) - 6'sd1) : -6'sd1;
                wr_d = wr_q - 6'sd1;
                if (wr_q == 6'sd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                we_d    = (lines_q != 3'd0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Renderer view: live input when idle, white overlay on full rows while flashing.
    always_comb begin
        disp_color = buf_q;
        if (state_q == IDLE) begin
            disp_color = board_in;
        end else if (state_q == FLASH) begin
            for (int r = 0; r < int'(GRID_H); r++) begin
                if (full_mask_q[r]) begin
                    disp_color[r*ROW_W +: ROW_W] = {GRID_W{WHITE}};
                end
            end
        end
    end

    assign board_out     = buf_q;
    assign board_we      = we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_t01_line_clear_ctrl.sv
// Self-checking bench for t01_line_clear_ctrl with a short flash period.
module tb_t01_line_clear_ctrl;

    localparam int BW = 600;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          gameover;
    logic [BW-1:0] board_in;
    logic [BW-1:0] disp_color;
    logic [BW-1:0] board_out;
    logic          board_we;
    logic          busy;
    logic          done;
    logic [2:0]    lines_cleared;

    typedef struct {
        string         name;
        logic [BW-1:0] bin;
        logic [BW-1:0] bexp;
        logic [BW-1:0] flash;
        logic [2:0]    lines;
        int            lat;
    } vec_t;

    vec_t vecs[5];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    t01_line_clear_ctrl #(.FLASH_CYCLES(24'd4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .gameover      (gameover),
        .board_in      (board_in),
        .disp_color    (disp_color),
        .board_out     (board_out),
        .board_we      (board_we),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    function automatic logic [BW-1:0] put_row(input logic [BW-1:0] b, input int r,
                                              input logic [29:0] v);
        logic [BW-1:0] t;
        t = b;
        t[r*30 +: 30] = v;
        return t;
    endfunction

    function automatic logic [29:0] solid(input logic [2:0] c);
        return {10{c}};
    endfunction

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_brd(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [BW-1:0] b);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        vec_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        lat  = 0;
        sb_q.push_back(v);
        start_op(v.bin);
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) check_int({v.name, " busy_during"}, int'(busy), 1);
            if (c == 22 && v.lines != 3'd0) check_brd({v.name, " flash_disp"}, disp_color, v.flash);
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        if (!seen || sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout: got no done expected done", v.name);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check_int({e.name, " latency"}, lat, e.lat);
            check_int({e.name, " board_we"}, int'(board_we), (e.lines != 3'd0) ? 1 : 0);
            check_int({e.name, " lines"}, int'(lines_cleared), int'(e.lines));
            if (e.lines != 3'd0) check_brd({e.name, " board_out"}, board_out, e.bexp);
            @(posedge clk);
            #1;
            check_int({e.name, " done_pulse"}, int'(done), 0);
            check_int({e.name, " busy_after"}, int'(busy), 0);
            check_brd({e.name, " disp_idle"}, disp_color, e.bin);
        end
    endtask

    task automatic random_no_full(output logic [BW-1:0] b);
        logic [29:0] row;
        int z;
        b = '0;
        for (int r = 0; r < 20; r++) begin
            for (int col = 0; col < 10; col++) row[col*3 +: 3] = 3'($urandom_range(7, 1));
            z = int'($urandom_range(9, 0));
            row[z*3 +: 3] = 3'b000;
            b = put_row(b, r, row);
        end
    endtask

    initial begin
        logic [BW-1:0] b;
        logic [29:0]   red5, pat_a, pat_b;
        int            ndone, lat;
        logic [BW-1:0] got_out;

        red5  = {{5{3'b000}}, {5{3'b100}}};
        pat_a = {3'b001, 3'b000, 3'b010, 3'b011, 3'b000, 3'b101, 3'b110, 3'b000, 3'b111, 3'b001};
        pat_b = {3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100};

        random_no_full(b);
        vecs[0] = '{name: "no_full_a", bin: b, bexp: '0, flash: '0, lines: 3'd0, lat: 21};

        b = put_row('0, 19, solid(3'b010));
        b = put_row(b, 18, red5);
        vecs[1] = '{name: "one_row", bin: b, bexp: put_row('0, 19, red5),
                    flash: put_row(put_row('0, 19, solid(3'b111)), 18, red5),
                    lines: 3'd1, lat: 45};

        b = put_row('0, 19, solid(3'b011));
        b = put_row(b, 18, pat_a);
        b = put_row(b, 17, solid(3'b101));
        b = put_row(b, 16, pat_b);
        vecs[2].name  = "two_rows";
        vecs[2].bin   = b;
        vecs[2].bexp  = put_row(put_row('0, 19, pat_a), 18, pat_b);
        vecs[2].flash = put_row(put_row(put_row(put_row('0, 19, solid(3'b111)), 18, pat_a),
                                        17, solid(3'b111)), 16, pat_b);
        vecs[2].lines = 3'd2;
        vecs[2].lat   = 45;

        b = put_row(put_row(put_row(put_row('0, 19, solid(3'b001)), 18, solid(3'b110)),
                            17, solid(3'b100)), 16, pat_a | solid(3'b001));
        vecs[3].name  = "four_rows";
        vecs[3].bin   = b;
        vecs[3].bexp  = '0;
        vecs[3].flash = put_row(put_row(put_row(put_row('0, 19, solid(3'b111)), 18, solid(3'b111)),
                                        17, solid(3'b111)), 16, solid(3'b111));
        vecs[3].lines = 3'd4;
        vecs[3].lat   = 45;

        random_no_full(b);
        vecs[4] = '{name: "no_full_b", bin: b, bexp: '0, flash: '0, lines: 3'd0, lat: 21};

        rst      = 1'b1;
        start    = 1'b0;
        gameover = 1'b0;
        board_in = vecs[1].bin;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset busy", int'(busy), 0);
        check_int("reset done", int'(done), 0);
        check_int("reset board_we", int'(board_we), 0);
        check_int("reset lines", int'(lines_cleared), 0);
        check_brd("reset board_out", board_out, '0);
        check_brd("reset disp", disp_color, vecs[1].bin);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_op(vecs[i]);

        // start held while gameover: must never be accepted
        @(negedge clk);
        gameover = 1'b1;
        board_in = vecs[1].bin;
        start    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_int("gameover busy", int'(busy), 0);
        end
        start    = 1'b0;
        gameover = 1'b0;

        // second start while busy must be ignored
        ndone   = 0;
        lat     = 0;
        got_out = '0;
        start_op(vecs[1].bin);
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) begin
                board_in = vecs[2].bin;
                start    = 1'b1;
            end else if (c == 4) begin
                board_in = vecs[1].bin;
                start    = 1'b0;
            end
            if (c == 30) gameover = 1'b1;
            if (done) begin
                ndone++;
                lat     = c;
                got_out = board_out;
            end
        end
        gameover = 1'b0;
        check_int("busy_start done_count", ndone, 1);
        check_int("busy_start latency", lat, 45);
        check_brd("busy_start board_out", got_out, vecs[1].bexp);

        // reset during FLASH aborts the operation
        start_op(vecs[1].bin);
        repeat (22) @(posedge clk);
        #1;
        check_brd("pre_reset flash_disp", disp_color, vecs[1].flash);
        rst = 1'b1;
        #1;
        check_int("async reset busy", int'(busy), 0);
        @(posedge clk);
        #1;
        check_int("reset_mid busy", int'(busy), 0);
        check_int("reset_mid done", int'(done), 0);
        check_int("reset_mid board_we", int'(board_we), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
